ym_bus_sequencer: RTL and testbench

Two-port bus sequencer and arbiter for the PSG register interface. It accepts register read and write transactions from two independent requesters, such as the CPU bridge and a register-stream replay engine. Each transaction becomes the PSG BDIR/BC bus protocol: an address-latch phase followed by a data phase. Contention is resolved round-robin. The block sits between the requesters and the PSG's BDIR/BC/DI/DO pins and is the only driver of those pins.

---
 rtl/ym_bus_sequencer.sv | 105 ++++++++++
 tb/tb_ym_bus_sequencer.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/ym_bus_sequencer.sv
// ym_bus_sequencer: two-port round-robin arbiter driving the PSG BDIR/BC/DI bus
// Ports:
//   CLK, RESET              clock, synchronous active-high reset
//   req*_i, we*_i           per-port request level and write/read select
//   addr*_i, wdata*_i       per-port PSG register number and write data
//   ack*_o, rdata*_o        per-port completion pulse and held read data
//   psg_bdir_o, psg_bc_o    PSG bus control
//   psg_di_o, psg_do_i      address/data to the PSG, read data from the PSG
//   busy_o                  high whenever a transaction or gap is in progress
module ym_bus_sequencer #(
  parameter int GAP_CYCLES = 0
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       we0_i,
  input  logic       we1_i,
  input  logic [3:0] addr0_i,
  input  logic [3:0] addr1_i,
  input  logic [7:0] wdata0_i,
  input  logic [7:0] wdata1_i,
  output logic       ack0_o,
  output logic       ack1_o,
  output logic [7:0] rdata0_o,
  output logic [7:0] rdata1_o,
  output logic       psg_bdir_o,
  output logic       psg_bc_o,
  output logic [7:0] psg_di_o,
  input  logic [7:0] psg_do_i,
  output logic       busy_o
);
  typedef enum logic [2:0] {IDLE, LATCH, XFER, DONE, GAP} state_t;
  localparam logic [3:0] GAP_LD = 4'(GAP_CYCLES - 1);
  state_t state_q, state_d;
  logic grant_q, prio_q, we_q, gnt_d, sel_we;
  logic bdir_q, bc_q, ack0_q, ack1_q, busy_q, bdir_d, bc_d;
  logic [3:0] gap_q, sel_addr;
  logic [7:0] wdata_q, rdata0_q, rdata1_q, di_q, sel_wdata, di_d;
  always_comb begin
    gnt_d = (req0_i && req1_i) ? prio_q : req1_i;
    sel_we = gnt_d ? we1_i : we0_i;
    sel_addr = gnt_d ? addr1_i : addr0_i;
    sel_wdata = gnt_d ? wdata1_i : wdata0_i;
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (req0_i || req1_i) ? LATCH : IDLE;
      LATCH:   state_d = XFER;
      XFER:    state_d = DONE;
      DONE:    state_d = (GAP_CYCLES > 0) ? GAP : IDLE;
      GAP:     state_d = (gap_q == 4'd0) ? IDLE : GAP;
      default: state_d = IDLE;
    endcase
    // LATCH is only ever entered from IDLE, so the address comes straight from the winning port
    bdir_d = (state_d == LATCH) || (state_d == XFER && we_q);
    bc_d = (state_d == LATCH) || (state_d == XFER && !we_q);
    di_d = (state_d == LATCH) ? {4'h0, sel_addr} : (state_d == XFER && we_q) ? wdata_q : 8'h00;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      prio_q <= 1'b0;
      we_q <= 1'b0;
      wdata_q <= 8'h00;
      gap_q <= 4'd0;
      bdir_q <= 1'b0;
      bc_q <= 1'b0;
      di_q <= 8'h00;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      busy_q <= 1'b0;
      rdata0_q <= 8'h00;
      rdata1_q <= 8'h00;
    end else begin
      state_q <= state_d;
      bdir_q <= bdir_d;
      bc_q <= bc_d;
      di_q <= di_d;
      ack0_q <= (state_d == DONE) && !grant_q;
      ack1_q <= (state_d == DONE) && grant_q;
      busy_q <= state_d != IDLE;
      if (state_q == IDLE && state_d == LATCH) begin
        grant_q <= gnt_d;
        prio_q <= ~gnt_d;
        we_q <= sel_we;
        wdata_q <= sel_wdata;
      end
      if (state_q == XFER && !we_q) begin
        if (grant_q) rdata1_q <= psg_do_i;
        else rdata0_q <= psg_do_i;
      end
      if (state_q == DONE) gap_q <= GAP_LD;
      else if (state_q == GAP) gap_q <= gap_q - 4'd1;
    end
  end
  assign psg_bdir_o = bdir_q;
  assign psg_bc_o = bc_q;
  assign psg_di_o = di_q;
  assign ack0_o = ack0_q;
  assign ack1_o = ack1_q;
  assign busy_o = busy_q;
  assign rdata0_o = rdata0_q;
  assign rdata1_o = rdata1_q;
endmodule

// File: tb/tb_ym_bus_sequencer.sv
// tb_ym_bus_sequencer: directed self-checking bench for ym_bus_sequencer
module tb_ym_bus_sequencer;
  logic CLK = 1'b0, RESET = 1'b1;
  logic req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [3:0] addr0 = 0, addr1 = 0;
  logic [7:0] wdata0 = 0, wdata1 = 0, psg_do = 0;
  logic ack0, ack1, bdir, bc, busy;
  logic [7:0] rdata0, rdata1, di;
  logic g_ack0, g_ack1, g_bdir, g_bc, g_busy;
  logic [7:0] g_rdata0, g_rdata1, g_di;
  int vecs = 0, errs = 0;
  always #5 CLK = ~CLK;
  ym_bus_sequencer #(.GAP_CYCLES(0)) u_dut (
    .CLK(CLK), .RESET(RESET), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(ack0), .ack1_o(ack1), .rdata0_o(rdata0), .rdata1_o(rdata1),
    .psg_bdir_o(bdir), .psg_bc_o(bc), .psg_di_o(di), .psg_do_i(psg_do), .busy_o(busy));
  ym_bus_sequencer #(.GAP_CYCLES(2)) u_gap (
    .CLK(CLK), .RESET(RESET), .req0_i(req0), .req1_i(req1), .we0_i(we0), .we1_i(we1),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .ack0_o(g_ack0), .ack1_o(g_ack1), .rdata0_o(g_rdata0), .rdata1_o(g_rdata1),
    .psg_bdir_o(g_bdir), .psg_bc_o(g_bc), .psg_di_o(g_di), .psg_do_i(psg_do), .busy_o(g_busy));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask
  task automatic do_reset();
    RESET = 1'b1;
    tick(2);
    RESET = 1'b0;
  endtask
  initial begin
    tick(2);
    RESET = 1'b0;
    check("rst_bus", {bdir, bc, di}, 10'h000);
    check("rst_ack", {ack0, ack1}, 2'b00);
    check("rst_rdata", {rdata0, rdata1}, 16'h0000);
    check("rst_busy", busy, 1'b0);
    // port0 write reg 7 = 0x38
    req0 = 1; we0 = 1; addr0 = 4'd7; wdata0 = 8'h38;
    tick();
    check("wr_latch", {bdir, bc, di}, {2'b11, 8'h07});
    check("wr_busy", busy, 1'b1);
    req0 = 0;
    tick();
    check("wr_xfer", {bdir, bc, di}, {2'b10, 8'h38});
    check("wr_noack", {ack0, ack1}, 2'b00);
    tick();
    check("wr_done", {bdir, bc, di}, 10'h000);
    check("wr_ack", {ack0, ack1}, 2'b10);
    check("wr_rdata", {rdata0, rdata1}, 16'h0000);
    tick();
    check("wr_idle", {ack0, ack1, busy}, 3'b000);
    // port1 read reg 14
    req1 = 1; we1 = 0; addr1 = 4'd14; psg_do = 8'hA5;
    tick();
    check("rd_latch", {bdir, bc, di}, {2'b11, 8'h0E});
    req1 = 0;
    tick();
    check("rd_xfer", {bdir, bc, di}, {2'b01, 8'h00});
    tick();
    check("rd_ack", {ack0, ack1}, 2'b01);
    check("rd_rdata1", rdata1, 8'hA5);
    check("rd_rdata0", rdata0, 8'h00);
    psg_do = 8'h11;
    tick();
    check("rd_hold", rdata1, 8'hA5);
    // input capture: port0 changes inputs during LATCH
    req0 = 1; we0 = 1; addr0 = 4'd3; wdata0 = 8'h55;
    tick();
    check("cap_latch", {bdir, bc, di}, {2'b11, 8'h03});
    req0 = 0; addr0 = 4'd9; wdata0 = 8'hAA;
    tick();
    check("cap_xfer", {bdir, bc, di}, {2'b10, 8'h55});
    tick();
    check("cap_ack", {ack0, ack1}, 2'b10);
    check("cap_rdata", {rdata0, rdata1}, {8'h00, 8'hA5});
    tick();
    // contention right after reset
    do_reset();
    req0 = 1; we0 = 1; addr0 = 4'd1; wdata0 = 8'h11;
    req1 = 1; we1 = 0; addr1 = 4'd2; psg_do = 8'h5A;
    tick();
    check("ct_first", di, 8'h01);
    tick(2);
    check("ct_ack0", {ack0, ack1}, 2'b10);
    req0 = 0;
    tick(2);
    check("ct_second", {bdir, bc, di}, {2'b11, 8'h02});
    tick(2);
    check("ct_ack1", {ack0, ack1}, 2'b01);
    check("ct_rdata1", rdata1, 8'h5A);
    req1 = 0;
    tick();
    req0 = 1; req1 = 1;
    tick();
    check("ct_third", di, 8'h01);
    tick(2);
    check("ct_ack0b", {ack0, ack1}, 2'b10);
    tick(2);
    check("ct_fourth", di, 8'h02);
    tick(2);
    check("ct_ack1b", {ack0, ack1}, 2'b01);
    tick(2);
    check("ct_fifth", di, 8'h01);
    req0 = 0; req1 = 0;
    tick(3);
    // gap spacing on the GAP_CYCLES=2 instance
    do_reset();
    req0 = 1; we0 = 1; addr0 = 4'd5; wdata0 = 8'h66;
    tick();
    check("gap_latch1", {g_bdir, g_bc, g_di}, {2'b11, 8'h05});
    tick(2);
    check("gap_ack", g_ack0, 1'b1);
    tick();
    check("gap_g1_busy", g_busy, 1'b1);
    check("gap_g1_bus", {g_bdir, g_bc, g_di}, 10'h000);
    tick();
    check("gap_g2_busy", g_busy, 1'b1);
    check("gap_g2_ack", g_ack0, 1'b0);
    tick();
    check("gap_idle", {g_busy, g_bdir, g_bc}, 3'b000);
    tick();
    check("gap_latch2", {g_bdir, g_bc, g_di}, {2'b11, 8'h05});
    req0 = 0;
    // reset during the XFER of a read
    do_reset();
    req1 = 1; we1 = 0; addr1 = 4'd4; psg_do = 8'hC3;
    tick(3);
    check("mr_pre", rdata1, 8'hC3);
    tick();
    req1 = 1;
    tick(2);
    check("mr_xfer", {bdir, bc}, 2'b01);
    RESET = 1'b1;
    req1 = 0;
    tick();
    check("mr_bus", {bdir, bc, di}, 10'h000);
    check("mr_ack", {ack0, ack1}, 2'b00);
    check("mr_rdata", {rdata0, rdata1}, 16'h0000);
    check("mr_busy", busy, 1'b0);
    RESET = 1'b0;
    req0 = 1; we0 = 1; addr0 = 4'd8; wdata0 = 8'h9C;
    tick();
    check("mr_latch", {bdir, bc, di}, {2'b11, 8'h08});
    req0 = 0;
    tick(2);
    check("mr_ack0", {ack0, ack1}, 2'b10);
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
